multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 36 +++
 rtl/multicycle_control.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle MIPS controller and its datapath:
// instruction fields and interrupt in, mux selects and write enables out.
interface multicycle_control_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       irq;
    logic [1:0] aluControl;
    logic [1:0] aluSrcB;
    logic       ALUSrcA;
    logic       PCSource;
    logic       lorD;
    logic       RegDst;
    logic       MemtoReg;
    logic       PCWrite;
    logic       isBranch;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       isInterrupted;
    logic       illegalOp;
    logic [3:0] state;

    modport slave (
        input  op, funct, irq,
        output aluControl, aluSrcB, ALUSrcA, PCSource, lorD, RegDst, MemtoReg,
               PCWrite, isBranch, IRWrite, MemWrite, RegWrite, isInterrupted,
               illegalOp, state
    );

    modport master (
        output op, funct, irq,
        input  aluControl, aluSrcB, ALUSrcA, PCSource, lorD, RegDst, MemtoReg,
               PCWrite, isBranch, IRWrite, MemWrite, RegWrite, isInterrupted,
               illegalOp, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM controller for a multicycle MIPS subset (lw, sw, R-type, beq, addi)
// with a deferred interrupt that redirects the PC at the next instruction fetch.
module multicycle_control (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.slave   bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        ILLEGAL = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    state_t      state_q, state_d;
    logic        irq_pending_q, irq_pending_d;
    logic [31:0] retired_q, retired_d;
    logic        funct_ok;
    logic [1:0]  exec_alu;
    logic        retire;

    always_comb begin
        funct_ok = 1'b1;
        exec_alu = ALU_ADD;
        case (bus.funct)
            6'b100000: exec_alu = ALU_ADD;
            6'b100010: exec_alu = ALU_SUB;
            6'b100100: exec_alu = ALU_AND;
            6'b100101: exec_alu = ALU_OR;
            default:   funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYP:      state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    default:      state_d = ILLEGAL;
                endcase
            end
            MEMADR: state_d = (bus.op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  state_d = MEMWB;
            EXEC:   state_d = funct_ok ? ALUWB : ILLEGAL;
            ADDIEX: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase

        // A new request wins over the clear performed at the end of FETCH.
        irq_pending_d = bus.irq | (irq_pending_q & (state_q != FETCH));

        retire    = (state_q == MEMWB) || (state_q == MEMWR) || (state_q == ALUWB) ||
                    (state_q == BRANCH) || (state_q == ADDIWB);
        retired_d = retire ? retired_q + 32'd1 : retired_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            irq_pending_q <= 1'b0;
            retired_q     <= 32'd0;
        end else begin
            state_q       <= state_d;
            irq_pending_q <= irq_pending_d;
            retired_q     <= retired_d;
        end
    end

    always_comb begin
        bus.aluControl    = ALU_ADD;
        bus.aluSrcB       = 2'b00;
        bus.ALUSrcA       = 1'b0;
        bus.PCSource      = 1'b0;
        bus.lorD          = 1'b0;
        bus.RegDst        = 1'b0;
        bus.MemtoReg      = 1'b0;
        bus.PCWrite       = 1'b0;
        bus.isBranch      = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.isInterrupted = 1'b0;
        bus.illegalOp     = 1'b0;
        bus.state         = state_q;
        case (state_q)
            FETCH: begin
                bus.IRWrite       = 1'b1;
                bus.PCWrite       = 1'b1;
                bus.aluSrcB       = 2'b01;
                bus.isInterrupted = irq_pending_q;
            end
            DECODE:  bus.aluSrcB = 2'b11;
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.aluSrcB = 2'b10;
            end
            MEMRD:   bus.lorD = 1'b1;
            MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
            end
            MEMWR: begin
                bus.lorD     = 1'b1;
                bus.MemWrite = 1'b1;
            end
            EXEC: begin
                bus.ALUSrcA    = 1'b1;
                bus.aluControl = exec_alu;
            end
            ALUWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA    = 1'b1;
                bus.aluControl = ALU_SUB;
                bus.PCSource   = 1'b1;
                bus.isBranch   = 1'b1;
            end
            ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.aluSrcB = 2'b10;
            end
            ADDIWB:  bus.RegWrite  = 1'b1;
            ILLEGAL: bus.illegalOp = 1'b1;
            default: ;
        endcase
        // Enables must drop the instant reset rises, not at the next edge.
        if (reset) begin
            bus.PCWrite       = 1'b0;
            bus.IRWrite       = 1'b0;
            bus.MemWrite      = 1'b0;
            bus.RegWrite      = 1'b0;
            bus.isBranch      = 1'b0;
            bus.isInterrupted = 1'b0;
            bus.illegalOp     = 1'b0;
        end
    end
endmodule
